// File: rtl/fir_seq_ctrl_if.sv
// fir_seq_ctrl_if: control, coefficient and status signals of the FIR sequencer
interface fir_seq_ctrl_if #(
  parameter int NUM_TAPS = 33
);
  logic iStart;
  logic iStop;
  logic iCoeffWr;
  logic [5:0] iCoeffAddr;
  logic [15:0] iCoeffData;
  logic iUpdate;
  logic iClrErr;
  logic oEnAcc;
  logic [16*NUM_TAPS-1:0] oCoeffBus;
  logic [1:0] oState;
  logic oUpdPend;
  logic [15:0] oSampleCnt;
  logic oErr;
  modport master (
    output iStart, iStop, iCoeffWr, iCoeffAddr, iCoeffData, iUpdate, iClrErr,
    input oEnAcc, oCoeffBus, oState, oUpdPend, oSampleCnt, oErr
  );
  modport slave (
    input iStart, iStop, iCoeffWr, iCoeffAddr, iCoeffData, iUpdate, iClrErr,
    output oEnAcc, oCoeffBus, oState, oUpdPend, oSampleCnt, oErr
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: FIR sample strobe sequencer and coefficient bank; define FIR_SEQ_CTRL_DBUF_EN for shadow/active double buffering
module fir_seq_ctrl #(
  parameter int NUM_TAPS = 33,
  parameter int SAMPLE_DIV = 12
) (
  input logic iClk_12M,
  input logic iRst,
  fir_seq_ctrl_if.slave bus
);
  localparam int W = 16 * NUM_TAPS;
  localparam logic [7:0] LAST = 8'(SAMPLE_DIV - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2} state_t;
  state_t state;
  logic [7:0] cnt;
  logic [7:0] cnt_n;
  logic addr_ok;
  logic wr_ok;
  logic [W-1:0] active;
  assign cnt_n = cnt == LAST ? 8'd0 : cnt + 8'd1;
  assign addr_ok = int'(bus.iCoeffAddr) < NUM_TAPS;
  assign wr_ok = bus.iCoeffWr && addr_ok;
  assign bus.oState = state;
  assign bus.oCoeffBus = active;
  // sequencing FSM, sample divider and registered accumulate strobe
  always_ff @(posedge iClk_12M or posedge iRst)
    if (iRst) begin
      state <= IDLE;
      cnt <= '0;
      bus.oEnAcc <= 1'b0;
      bus.oSampleCnt <= '0;
    end else begin
      if (bus.oEnAcc) bus.oSampleCnt <= bus.oSampleCnt + 16'd1;
      case (state)
        IDLE: if (bus.iStart && !bus.iStop) begin
          state <= RUN;
          cnt <= '0;
        end
        RUN: begin
          cnt <= cnt_n;
          bus.oEnAcc <= cnt_n == LAST;
          if (bus.iStop) state <= STOPPING;
        end
        STOPPING: if (bus.oEnAcc) begin
          state <= IDLE;
          cnt <= '0;
          bus.oEnAcc <= 1'b0;
        end else begin
          cnt <= cnt_n;
          bus.oEnAcc <= cnt_n == LAST;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef FIR_SEQ_CTRL_DBUF_EN
  logic [W-1:0] shadow;
  logic [W-1:0] shadow_n;
  logic commit;
  // shadow bank including this cycle's legal write, so a coinciding commit picks it up
  always_comb begin
    shadow_n = shadow;
    if (wr_ok) shadow_n[{bus.iCoeffAddr, 4'd0} +: 16] = bus.iCoeffData;
  end
  assign commit = (bus.oUpdPend || bus.iUpdate) && (state == IDLE || bus.oEnAcc);
  // shadow writes, commit on sample boundary (or at once when idle), sticky error
  always_ff @(posedge iClk_12M or posedge iRst)
    if (iRst) begin
      shadow <= '0;
      active <= '0;
      bus.oUpdPend <= 1'b0;
      bus.oErr <= 1'b0;
    end else begin
      shadow <= shadow_n;
      if (commit) active <= shadow_n;
      bus.oUpdPend <= (bus.oUpdPend || bus.iUpdate) && !commit;
      bus.oErr <= (bus.iCoeffWr && !addr_ok) || (bus.oErr && !bus.iClrErr);
    end
`else
  logic unused_upd;
  assign unused_upd = bus.iUpdate;
  assign bus.oUpdPend = 1'b0;
  // direct writes to the active bank only while idle, sticky error otherwise
  always_ff @(posedge iClk_12M or posedge iRst)
    if (iRst) begin
      active <= '0;
      bus.oErr <= 1'b0;
    end else begin
      if (wr_ok && state == IDLE) active[{bus.iCoeffAddr, 4'd0} +: 16] <= bus.iCoeffData;
      bus.oErr <= (bus.iCoeffWr && (!addr_ok || state != IDLE)) || (bus.oErr && !bus.iClrErr);
    end
`endif
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: directed scoreboard bench for fir_seq_ctrl
module tb_fir_seq_ctrl;
  localparam int NT = 33;
  localparam int W = 16 * NT;
  logic iClk_12M = 1'b0;
  logic iRst = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int exp_q[$];
  logic [W-1:0] exp_bus = '0;
  int c0;
  int c1;
  fir_seq_ctrl_if #(.NUM_TAPS(NT)) bus ();
  fir_seq_ctrl #(.NUM_TAPS(NT), .SAMPLE_DIV(12)) dut (
    .iClk_12M(iClk_12M),
    .iRst(iRst),
    .bus(bus.slave)
  );
  always #5 iClk_12M = ~iClk_12M;
  always @(posedge iClk_12M) cyc <= cyc + 1;
  // every strobe must match the next scheduled pulse cycle
  always @(negedge iClk_12M)
    if (bus.oEnAcc) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_pulse observed=cycle %0d expected=no pulse", cyc);
      end
      if (exp_q.size() != 0) begin
        int e;
        e = exp_q.pop_front();
        tests++;
        assert (cyc === e) else begin
          fails++;
          $error("FAIL pulse_cycle observed=%0d expected=%0d", cyc, e);
        end
      end
    end
  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_bus(input string tag);
    tests++;
    assert (bus.oCoeffBus === exp_bus) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, bus.oCoeffBus, exp_bus);
    end
  endtask
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge iClk_12M);
  endtask
  task automatic write(input logic [5:0] a, input logic [15:0] d, input logic upd, input logic clr);
    bus.iCoeffWr = 1'b1;
    bus.iCoeffAddr = a;
    bus.iCoeffData = d;
    bus.iUpdate = upd;
    bus.iClrErr = clr;
    @(negedge iClk_12M);
    bus.iCoeffWr = 1'b0;
    bus.iUpdate = 1'b0;
    bus.iClrErr = 1'b0;
  endtask
  initial begin
    bus.iStart = 0;
    bus.iStop = 0;
    bus.iCoeffWr = 0;
    bus.iCoeffAddr = 0;
    bus.iCoeffData = 0;
    bus.iUpdate = 0;
    bus.iClrErr = 0;
    repeat (2) @(negedge iClk_12M);
    check("rst_state", bus.oState, 0);
    check("rst_en", bus.oEnAcc, 0);
    check("rst_cnt", bus.oSampleCnt, 0);
    check("rst_pend", bus.oUpdPend, 0);
    check("rst_err", bus.oErr, 0);
    check_bus("rst_bus");
    iRst = 1'b0;
    @(negedge iClk_12M);
    check("idle_state", bus.oState, 0);
    write(6'd0, 16'h0100, 1'b1, 1'b0);
    exp_bus[15:0] = 16'h0100;
    check_bus("idle_write");
    check("idle_pend", bus.oUpdPend, 0);
    check("idle_err", bus.oErr, 0);
    write(6'd33, 16'h7FFF, 1'b0, 1'b0);
    check("bad_addr_err", bus.oErr, 1);
    check_bus("bad_addr_bus");
    write(6'd40, 16'h7FFF, 1'b0, 1'b1);
    check("err_set_prio", bus.oErr, 1);
    bus.iClrErr = 1'b1;
    @(negedge iClk_12M);
    bus.iClrErr = 1'b0;
    check("err_clr", bus.oErr, 0);
    c0 = cyc;
    bus.iStart = 1'b1;
    for (int k = 1; k <= 5; k++) exp_q.push_back(c0 + 12 * k);
    @(negedge iClk_12M);
    bus.iStart = 1'b0;
    check("run_state", bus.oState, 1);
    wait_cyc(c0 + 37);
    check("three_samples", bus.oSampleCnt, 3);
`ifdef FIR_SEQ_CTRL_DBUF_EN
    wait_cyc(c0 + 45);
    write(6'd5, 16'h1234, 1'b1, 1'b0);
    check("dbuf_pend_set", bus.oUpdPend, 1);
    check_bus("dbuf_hold_early");
    wait_cyc(c0 + 48);
    check("dbuf_pend_at_pulse", bus.oUpdPend, 1);
    check_bus("dbuf_hold_pulse");
    @(negedge iClk_12M);
    exp_bus[95:80] = 16'h1234;
    check_bus("dbuf_commit");
    check("dbuf_pend_clr", bus.oUpdPend, 0);
`else
    write(6'd0, 16'h0200, 1'b0, 1'b0);
    check("run_write_err", bus.oErr, 1);
    check_bus("run_write_ignored");
    bus.iClrErr = 1'b1;
    @(negedge iClk_12M);
    bus.iClrErr = 1'b0;
    check("run_err_clr", bus.oErr, 0);
`endif
    wait_cyc(c0 + 52);
    bus.iStop = 1'b1;
    @(negedge iClk_12M);
    bus.iStop = 1'b0;
    check("stopping_state", bus.oState, 2);
    wait_cyc(c0 + 60);
    check("stopping_last", bus.oState, 2);
    check("final_pulse", bus.oEnAcc, 1);
    @(negedge iClk_12M);
    check("stopped_state", bus.oState, 0);
    check("five_samples", bus.oSampleCnt, 5);
    wait_cyc(c0 + 90);
    check("idle_hold_cnt", bus.oSampleCnt, 5);
    c1 = cyc;
    bus.iStart = 1'b1;
    exp_q.push_back(c1 + 12);
    @(negedge iClk_12M);
    bus.iStart = 1'b0;
    wait_cyc(c1 + 14);
    write(6'd50, 16'h5555, 1'b1, 1'b0);
    wait_cyc(c1 + 20);
    check("pre_rst_cnt", bus.oSampleCnt, 6);
    check("pre_rst_err", bus.oErr, 1);
`ifdef FIR_SEQ_CTRL_DBUF_EN
    check("pre_rst_pend", bus.oUpdPend, 1);
`endif
    #2 iRst = 1'b1;
    #1;
    exp_bus = '0;
    check("arst_state", bus.oState, 0);
    check("arst_en", bus.oEnAcc, 0);
    check("arst_cnt", bus.oSampleCnt, 0);
    check("arst_pend", bus.oUpdPend, 0);
    check("arst_err", bus.oErr, 0);
    check_bus("arst_bus");
    @(negedge iClk_12M);
    iRst = 1'b0;
    repeat (30) @(negedge iClk_12M);
    check("post_rst_state", bus.oState, 0);
    check("post_rst_cnt", bus.oSampleCnt, 0);
    bus.iStart = 1'b1;
    bus.iStop = 1'b1;
    @(negedge iClk_12M);
    bus.iStart = 1'b0;
    bus.iStop = 1'b0;
    check("start_stop_idle", bus.oState, 0);
    repeat (15) @(negedge iClk_12M);
    check("no_run_cnt", bus.oSampleCnt, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
